// File: rtl/al_accel_cfg_pkg.sv
// Shared register-map constants and commit FSM states for the accelerator config register file.
package al_accel_cfg_pkg;

  localparam int NUM_CFG_WORDS = 17;

  localparam logic [4:0] SEL_CFG0   = 5'd0;
  localparam logic [4:0] SEL_CFG1   = 5'd1;
  localparam logic [4:0] SEL_CFG2   = 5'd2;
  localparam logic [4:0] SEL_CFG3   = 5'd3;
  localparam logic [4:0] SEL_CFG4   = 5'd4;
  localparam logic [4:0] SEL_CFG5   = 5'd5;
  localparam logic [4:0] SEL_CFG6   = 5'd6;
  localparam logic [4:0] SEL_CFG7   = 5'd7;
  localparam logic [4:0] SEL_CFG8   = 5'd8;
  localparam logic [4:0] SEL_CFG9   = 5'd9;
  localparam logic [4:0] SEL_CFG10  = 5'd10;
  localparam logic [4:0] SEL_CFG11  = 5'd11;
  localparam logic [4:0] SEL_QPTR   = 5'd12;
  localparam logic [4:0] SEL_QMUL   = 5'd13;
  localparam logic [4:0] SEL_QSHIFT = 5'd14;
  localparam logic [4:0] SEL_CFG15  = 5'd15;
  localparam logic [4:0] SEL_CFG16  = 5'd16;
  localparam logic [4:0] SEL_STATUS = 5'd17;

  localparam int QPTR_PTR_LSB      = 0;
  localparam int QPTR_AUTO_INC_BIT = 8;

  // Word 5 only carries a 16-bit field.
  localparam logic [31:0] SEL5_MASK = 32'h0000_FFFF;

  typedef enum logic [0:0] {
    COMMIT_IDLE = 1'b0,
    COMMIT_PEND = 1'b1
  } commit_state_e;

  function automatic logic is_staging_sel(input logic [4:0] sel);
    return (sel <= SEL_CFG11) || (sel == SEL_CFG15) || (sel == SEL_CFG16);
  endfunction

endpackage

// File: rtl/al_accel_cfg_regfile_v2_if.sv
// CPU-side config bus between the host and the register file.
interface al_accel_cfg_regfile_v2_if;
  logic        config_wen;
  logic        config_ren;
  logic [4:0]  config_sel;
  logic [31:0] config_data;
  logic [31:0] rd_data;
  logic        rd_valid;

  modport master (
    output config_wen, config_ren, config_sel, config_data,
    input  rd_data, rd_valid
  );

  modport slave (
    input  config_wen, config_ren, config_sel, config_data,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/al_accel_cfg_regfile_v2_quant_lane_buf.sv
// Quant multiplier/shift buffers with auto-incrementing write pointer, busy lock,
// range check and a registered lane-group output.
module al_quant_lane_buf
  import al_accel_cfg_pkg::*;
#(
  parameter  int NUM_LANES  = 3,
  parameter  int QBUF_DEPTH = 36,
  localparam int NUM_GRP    = QBUF_DEPTH / NUM_LANES,
  localparam int GRP_W      = $clog2(NUM_GRP + 1),
  localparam int PTR_W      = $clog2(QBUF_DEPTH)
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    wen,
  input  logic [4:0]              sel,
  input  logic [31:0]             data,
  input  logic                    layer_busy,
  input  logic [GRP_W-1:0]        grp_sel,
  output logic [PTR_W-1:0]        ptr,
  output logic                    auto_inc,
  output logic [31:0]             rd_mult,
  output logic [7:0]              rd_shift,
  output logic                    wr_err,
  output logic [32*NUM_LANES-1:0] output_multiplier,
  output logic [8*NUM_LANES-1:0]  output_shift
);

  logic [31:0]             mult_r  [QBUF_DEPTH];
  logic [7:0]              shift_r [QBUF_DEPTH];
  logic [PTR_W-1:0]        ptr_r;
  logic                    auto_inc_r;
  logic [32*NUM_LANES-1:0] mult_out_r;
  logic [8*NUM_LANES-1:0]  shift_out_r;

  logic                    qwr_s;
  logic                    in_range_s;
  logic                    accept_s;
  logic                    grp_valid_s;
  logic [32*NUM_LANES-1:0] mult_nxt_s;
  logic [8*NUM_LANES-1:0]  shift_nxt_s;

  assign qwr_s       = wen && ((sel == SEL_QMUL) || (sel == SEL_QSHIFT));
  assign in_range_s  = int'(ptr_r) < QBUF_DEPTH;
  assign accept_s    = qwr_s && !layer_busy && in_range_s;
  assign wr_err      = qwr_s && !accept_s;
  assign grp_valid_s = (grp_sel != '0) && (int'(grp_sel) <= NUM_GRP);

  // Pointer and auto-increment mode; only shift writes advance the pointer.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ptr_r      <= '0;
      auto_inc_r <= 1'b0;
    end else if (wen && (sel == SEL_QPTR)) begin
      ptr_r      <= data[QPTR_PTR_LSB +: PTR_W];
      auto_inc_r <= data[QPTR_AUTO_INC_BIT];
    end else if (accept_s && (sel == SEL_QSHIFT) && auto_inc_r) begin
      ptr_r <= (ptr_r == PTR_W'(QBUF_DEPTH - 1)) ? '0 : ptr_r + PTR_W'(1);
    end
  end

  // Buffer storage.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < QBUF_DEPTH; i++) begin
        mult_r[i]  <= 32'd0;
        shift_r[i] <= 8'd0;
      end
    end else if (accept_s) begin
      if (sel == SEL_QMUL) begin
        mult_r[ptr_r] <= data;
      end else begin
        shift_r[ptr_r] <= data[7:0];
      end
    end
  end

  // Lane-group selection; invalid groups present all-zero lanes.
  always_comb begin
    mult_nxt_s  = '0;
    shift_nxt_s = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (grp_valid_s) begin
        mult_nxt_s[32*k +: 32] = mult_r[PTR_W'((int'(grp_sel) - 1) * NUM_LANES + k)];
        shift_nxt_s[8*k +: 8]  = shift_r[PTR_W'((int'(grp_sel) - 1) * NUM_LANES + k)];
      end else begin
        mult_nxt_s[32*k +: 32] = 32'd0;
        shift_nxt_s[8*k +: 8]  = 8'd0;
      end
    end
  end

  // Registered group output.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mult_out_r  <= '0;
      shift_out_r <= '0;
    end else begin
      mult_out_r  <= mult_nxt_s;
      shift_out_r <= shift_nxt_s;
    end
  end

  assign ptr               = ptr_r;
  assign auto_inc          = auto_inc_r;
  assign rd_mult           = in_range_s ? mult_r[ptr_r] : 32'd0;
  assign rd_shift          = in_range_s ? shift_r[ptr_r] : 8'd0;
  assign output_multiplier = mult_out_r;
  assign output_shift      = shift_out_r;

endmodule

// File: rtl/al_accel_cfg_regfile_v2.sv
// Double-buffered accelerator config register file: staging bank, commit into the active bank,
// quant buffers and optional readback (enabled by defining AL_CFG_READBACK_EN).
module al_accel_cfg_regfile_v2
  import al_accel_cfg_pkg::*;
#(
  parameter  int NUM_LANES  = 3,
  parameter  int QBUF_DEPTH = 36,
  localparam int NUM_GRP    = QBUF_DEPTH / NUM_LANES,
  localparam int GRP_W      = $clog2(NUM_GRP + 1)
) (
  input  logic                          clk,
  input  logic                          resetn,
  al_accel_cfg_regfile_v2_if.slave      cfg,
  input  logic                          commit_req,
  input  logic                          layer_busy,
  output logic                          commit_ack,
  output logic                          commit_pending,
  output logic [32*NUM_CFG_WORDS-1:0]   active_cfg,
  input  logic [GRP_W-1:0]              quant_grp_sel,
  output logic [32*NUM_LANES-1:0]       output_multiplier,
  output logic [8*NUM_LANES-1:0]        output_shift,
  output logic                          cfg_err
);

  localparam int PTR_W = $clog2(QBUF_DEPTH);

  logic [31:0]      staging_r [NUM_CFG_WORDS];
  logic [31:0]      active_r  [NUM_CFG_WORDS];
  commit_state_e    state_r;
  commit_state_e    state_nxt_s;
  logic             copy_s;
  logic             commit_ack_r;
  logic             cfg_err_r;
  logic             qerr_s;
  logic [PTR_W-1:0] qbuf_ptr_s;
  logic             auto_inc_s;
  logic [31:0]      rd_mult_s;
  logic [7:0]       rd_shift_s;

  al_quant_lane_buf #(
    .NUM_LANES  (NUM_LANES),
    .QBUF_DEPTH (QBUF_DEPTH)
  ) u_qbuf (
    .clk               (clk),
    .resetn            (resetn),
    .wen               (cfg.config_wen),
    .sel               (cfg.config_sel),
    .data              (cfg.config_data),
    .layer_busy        (layer_busy),
    .grp_sel           (quant_grp_sel),
    .ptr               (qbuf_ptr_s),
    .auto_inc          (auto_inc_s),
    .rd_mult           (rd_mult_s),
    .rd_shift          (rd_shift_s),
    .wr_err            (qerr_s),
    .output_multiplier (output_multiplier),
    .output_shift      (output_shift)
  );

  // Staging bank; words 12-14 are never written and stay zero.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_CFG_WORDS; i++) begin
        staging_r[i] <= 32'd0;
      end
    end else if (cfg.config_wen && is_staging_sel(cfg.config_sel)) begin
      staging_r[cfg.config_sel] <= (cfg.config_sel == SEL_CFG5) ?
                                   (cfg.config_data & SEL5_MASK) : cfg.config_data;
    end
  end

  // Active bank copies the pre-edge staging contents.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_CFG_WORDS; i++) begin
        active_r[i] <= 32'd0;
      end
    end else if (copy_s) begin
      for (int i = 0; i < NUM_CFG_WORDS; i++) begin
        active_r[i] <= staging_r[i];
      end
    end
  end

  // Commit FSM state register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r <= COMMIT_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Commit FSM next state; repeated requests while pending are absorbed.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      COMMIT_IDLE: begin
        if (commit_req && layer_busy) begin
          state_nxt_s = COMMIT_PEND;
        end else begin
          state_nxt_s = COMMIT_IDLE;
        end
      end
      COMMIT_PEND: begin
        if (!layer_busy) begin
          state_nxt_s = COMMIT_IDLE;
        end else begin
          state_nxt_s = COMMIT_PEND;
        end
      end
      default: state_nxt_s = COMMIT_IDLE;
    endcase
  end

  // Commit FSM outputs.
  always_comb begin
    copy_s = 1'b0;
    case (state_r)
      COMMIT_IDLE: copy_s = commit_req && !layer_busy;
      COMMIT_PEND: copy_s = !layer_busy;
      default:     copy_s = 1'b0;
    endcase
  end

  // Ack and sticky error flag; a new error wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      commit_ack_r <= 1'b0;
      cfg_err_r    <= 1'b0;
    end else begin
      commit_ack_r <= copy_s;
      if (qerr_s) begin
        cfg_err_r <= 1'b1;
      end else if (cfg.config_wen && (cfg.config_sel == SEL_STATUS)) begin
        cfg_err_r <= 1'b0;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_CFG_WORDS; gi++) begin : g_active
    assign active_cfg[32*gi +: 32] = active_r[gi];
  end

  assign commit_ack     = commit_ack_r;
  assign commit_pending = (state_r == COMMIT_PEND);
  assign cfg_err        = cfg_err_r;

`ifdef AL_CFG_READBACK_EN
  logic [31:0] rd_mux_s;
  logic [31:0] rd_data_r;
  logic        rd_valid_r;

  // Read mux returns the staging view, never the active bank.
  always_comb begin
    rd_mux_s = 32'd0;
    case (cfg.config_sel)
      SEL_QPTR:   rd_mux_s = {23'd0, auto_inc_s, 8'(qbuf_ptr_s)};
      SEL_QMUL:   rd_mux_s = rd_mult_s;
      SEL_QSHIFT: rd_mux_s = {24'd0, rd_shift_s};
      SEL_STATUS: rd_mux_s = {30'd0, commit_pending, cfg_err_r};
      default: begin
        if (is_staging_sel(cfg.config_sel)) begin
          rd_mux_s = staging_r[cfg.config_sel];
        end else begin
          rd_mux_s = 32'd0;
        end
      end
    endcase
  end

  // Readback register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_data_r  <= 32'd0;
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= cfg.config_ren;
      if (cfg.config_ren) begin
        rd_data_r <= rd_mux_s;
      end
    end
  end

  assign cfg.rd_data  = rd_data_r;
  assign cfg.rd_valid = rd_valid_r;
`else
  logic unused_rd_s;
  assign unused_rd_s  = ^{cfg.config_ren, qbuf_ptr_s, auto_inc_s, rd_mult_s, rd_shift_s};
  assign cfg.rd_data  = 32'd0;
  assign cfg.rd_valid = 1'b0;
`endif

endmodule
